first_nios2_system_irq_controller: RTL and testbench
====================================================

# first_nios2_system_irq_controller

Interrupt aggregation stage that sits downstream of the system clock timer and other peripheral interrupt sources and feeds a single interrupt request to the Nios II CPU. It latches or tracks each source, applies a per-source enable mask, reports the highest-priority (lowest-numbered) active source, and exposes all state through a 16-bit Avalon-MM slave. Source 0 is wired to the timer `irq`; the timer's own status write clears that level at its origin.

## Interface
- `NUM_IRQ`, 8: number of interrupt sources, legal range 1..16.
- `EDGE_MASK`, 16'h0000: bit i = 1 makes source i edge-sensitive (latched); 0 = level-sensitive. Bits ≥ NUM_IRQ ignored.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 16: write data.
- `irq_in` in NUM_IRQ: interrupt sources, synchronous to `clk`, active-high.
- `readdata` out 16: registered read data.
- `irq` out 1: combined interrupt to CPU, active-high.

## Operation
- Register map (word addresses):
  - 0 PENDING: R = pending[NUM_IRQ-1:0]; W = write-1-to-clear for edge sources, ignored for level bits.
  - 1 ENABLE: R/W, NUM_IRQ bits; unused `writedata` bits ignored.
  - 2 ACTIVE: R = pending & enable.
  - 3 INDEX: R = {valid, 11'b0, idx[3:0]}; valid = |ACTIVE; idx = lowest set bit of ACTIVE, 0 when not valid.
  - 4 RAW: R = `irq_in` delayed one cycle (`irq_in_d`).
  - 5 SET: W = write-1-to-set pending for edge sources; level bits ignored; reads 0.
  - 6, 7: read 0, writes ignored.
- All reads zero-extended above NUM_IRQ. A write strobe is `chipselect && !write_n`.
- Level source i: pending[i] <= irq_in[i] every cycle.
- Edge source i:
  - Rising edge = irq_in[i] & ~irq_in_d[i] sets pending[i].
  - Priority when simultaneous: set (edge or SET write) beats W1C clear.
  - Holding irq_in high produces no further set after a clear.
- `irq` = |(pending & enable), combinational from registers; no output glitch source beyond register outputs.
- ENABLE masks only `irq`/ACTIVE/INDEX; pending keeps accumulating while disabled.
- Reset: pending, enable, irq_in_d, readdata = 0; hence `irq` = 0. An edge source high when reset is released counts as a rising edge on the first active cycle.

## Timing
- Source → `irq`: irq_in rises in cycle N → pending set at edge ending N → `irq` high in cycle N+1 (one-cycle latency), given enable already set.
- ENABLE write in cycle N → `irq` reflects new mask in N+1.
- W1C in cycle N → pending and `irq` low in N+1, unless a set occurs in cycle N.
- Level source falls in cycle N → `irq` low in N+1.
- Reads: `readdata` registered every cycle from the address mux regardless of `chipselect`. Data is valid the cycle after the address is presented; zero wait states beyond that. Read value reflects state before any same-cycle write.
- Reset asserted mid-operation: the next edge clears all state; writes in the reset cycle are discarded.

## Test plan
- Reset, then read address 0..7 → all `readdata` 0; `irq` 0.
- EDGE_MASK=16'h0001, ENABLE=8'h01, pulse irq_in[0] one cycle at N → `irq` high from N+1. Hold it 20 cycles → PENDING reads 16'h0001; write 16'h0001 to address 0 → `irq` low next cycle and stays low.
- Level source 3 held high with ENABLE=0 → ACTIVE 0, RAW 16'h0008, `irq` 0. Write ENABLE=8'h08 → `irq` high next cycle. Drop irq_in[3] → `irq` low one cycle later.
- Sources 2 and 5 active and enabled → INDEX reads 16'h8002. Clear/drop 2 → INDEX reads 16'h8005. None active → 16'h0000.
- Edge on source 0 in the same cycle as a W1C to bit 0 → pending[0] remains 1.
- SET write 16'h00FF with EDGE_MASK=16'h0001 → PENDING reads 16'h0001 only. Assert `reset` mid-pending → all registers 0 and `irq` 0 next cycle.

Source files
------------

// File: rtl/first_nios2_system_irq_controller.sv
// Interrupt aggregator for the Nios II CPU: per-source latch/track,
// enable mask, lowest-index priority and a 16-bit Avalon-MM slave.
module first_nios2_system_irq_controller #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [NUM_IRQ-1:0] EMASK = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] irq_in_d;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] setw;
  logic [NUM_IRQ-1:0] edge_nxt;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [3:0]         idx;
  logic [15:0]        rd_nxt;
  logic               wr;
  logic               unused_ok;

  function automatic logic [15:0] zext(
    input logic [NUM_IRQ-1:0] v
  );
    zext = '0;
    zext[NUM_IRQ-1:0] = v;
  endfunction

  assign wr        = chipselect && !write_n;
  assign unused_ok = ^writedata;
  assign active    = pending & enable;
  assign irq       = |active;
  assign rise      = irq_in & ~irq_in_d;

  always_comb begin
    clr  = '0;
    setw = '0;
    if (wr && address == 3'd0)
      clr = writedata[NUM_IRQ-1:0];
    if (wr && address == 3'd5)
      setw = writedata[NUM_IRQ-1:0];
  end

  // Sets are applied after the clear so they win a same-cycle collision.
  assign edge_nxt = (pending & ~clr) | rise | setw;
  assign pend_nxt = (EMASK & edge_nxt)
                  | (~EMASK & irq_in);

  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i])
        idx = 4'(i);
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      3'd0:    rd_nxt = zext(pending);
      3'd1:    rd_nxt = zext(enable);
      3'd2:    rd_nxt = zext(active);
      3'd3:    rd_nxt = {irq, 11'b0, idx};
      3'd4:    rd_nxt = zext(irq_in_d);
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      enable   <= '0;
      irq_in_d <= '0;
      readdata <= '0;
    end else begin
      pending  <= pend_nxt;
      irq_in_d <= irq_in;
      readdata <= rd_nxt;
      if (wr && address == 3'd1)
        enable <= writedata[NUM_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_first_nios2_system_irq_controller.sv
// Directed bench: driver queues expected reads/irq levels,
// a monitor pops and compares when the DUT presents them.
module tb_first_nios2_system_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [7:0]  irq_in;
  logic [15:0] readdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t rdq[$];
  exp_t irqq[$];
  int   errors = 0;
  int   checks = 0;
  logic tag_rd = 1'b0;
  logic tag_irq = 1'b0;
  logic rd_seen = 1'b0;

  first_nios2_system_irq_controller #(
    .NUM_IRQ  (8),
    .EDGE_MASK(16'h0001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .irq_in    (irq_in),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_seen <= tag_rd;

  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got=%h", readdata);
      end else begin
        e = rdq.pop_front();
        if (readdata !== e.exp) begin
          errors++;
          $display("FAIL %s readdata got=%h exp=%h",
                   e.name, readdata, e.exp);
        end
      end
    end
    if (tag_irq) begin
      checks++;
      if (irqq.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected got=%b", irq);
      end else begin
        e = irqq.pop_front();
        if (irq !== e.exp[0]) begin
          errors++;
          $display("FAIL %s irq got=%b exp=%b",
                   e.name, irq, e.exp[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tag_rd     = 1'b0;
    tag_irq    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc();
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] x,
                    input string nm);
    cyc();
    address    = a;
    chipselect = 1'b1;
    tag_rd     = 1'b1;
    rdq.push_back('{nm, x});
  endtask

  task automatic exp_irq(input logic x, input string nm);
    tag_irq = 1'b1;
    irqq.push_back('{nm, {15'b0, x}});
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_irq(1'b0, "rst_irq");

    for (int a = 0; a < 8; a++)
      rd(3'(a), 16'h0000, $sformatf("rst_rd%0d", a));

    // edge source 0
    wr(3'd1, 16'h0001);
    cyc();
    irq_in[0] = 1'b1;
    exp_irq(1'b0, "edge_before");
    cyc();
    exp_irq(1'b1, "edge_lat1");
    idle(18);
    exp_irq(1'b1, "edge_hold");
    rd(3'd0, 16'h0001, "edge_pend");
    wr(3'd0, 16'h0001);
    cyc();
    exp_irq(1'b0, "w1c_low");
    idle(5);
    exp_irq(1'b0, "w1c_stays");
    cyc();
    irq_in[0] = 1'b0;

    // level source 3
    wr(3'd1, 16'h0000);
    cyc();
    irq_in[3] = 1'b1;
    rd(3'd2, 16'h0000, "lvl_active");
    rd(3'd4, 16'h0008, "lvl_raw");
    exp_irq(1'b0, "lvl_masked");
    wr(3'd1, 16'h0008);
    cyc();
    exp_irq(1'b1, "lvl_en");
    cyc();
    irq_in[3] = 1'b0;
    exp_irq(1'b1, "lvl_drop0");
    cyc();
    exp_irq(1'b0, "lvl_drop1");

    // priority index
    wr(3'd1, 16'h0024);
    cyc();
    irq_in[2] = 1'b1;
    irq_in[5] = 1'b1;
    rd(3'd3, 16'h8002, "idx_2");
    cyc();
    irq_in[2] = 1'b0;
    rd(3'd3, 16'h8005, "idx_5");
    cyc();
    irq_in[5] = 1'b0;
    rd(3'd3, 16'h0000, "idx_none");
    exp_irq(1'b0, "idx_irq");

    // edge collides with W1C
    wr(3'd1, 16'h0001);
    wr(3'd0, 16'h0001);
    irq_in[0] = 1'b1;
    cyc();
    irq_in[0] = 1'b0;
    exp_irq(1'b1, "set_wins");
    rd(3'd0, 16'h0001, "set_wins_pend");
    wr(3'd0, 16'h0001);
    cyc();
    exp_irq(1'b0, "clr_after");

    // SET register: only edge bits respond
    wr(3'd5, 16'h00FF);
    cyc();
    exp_irq(1'b1, "set_irq");
    rd(3'd0, 16'h0001, "set_pend");
    rd(3'd5, 16'h0000, "set_rd0");
    rd(3'd1, 16'h0001, "en_rb");

    // reset mid-pending, write in reset cycle discarded
    cyc();
    reset      = 1'b1;
    address    = 3'd1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 16'h00FF;
    cyc();
    reset = 1'b0;
    exp_irq(1'b0, "mid_rst_irq");
    rd(3'd0, 16'h0000, "mid_rst_pend");
    rd(3'd1, 16'h0000, "mid_rst_en");
    rd(3'd4, 16'h0000, "mid_rst_raw");

    idle(2);
    for (int k = 0; k < 10; k++)
      if (rdq.size() != 0 || irqq.size() != 0)
        cyc();
    if (rdq.size() != 0 || irqq.size() != 0) begin
      errors += rdq.size() + irqq.size();
      $display("FAIL drain left=%0d exp=0",
               rdq.size() + irqq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
